// File: rtl/reg_watch_pkg.sv
// reg_watch_pkg: shared definitions for the register-watch monitor.
//   ch_state_e  : per-channel watch state (IDLE / ARMED / PASS / FAIL)
//   TMO_DISABLE : cfg_timeout value that disables the channel timeout
//   X0_IDX      : index of the hardwired-zero register, never matched by a write
package reg_watch_pkg;

  typedef enum logic [1:0] {
    CH_IDLE  = 2'd0,
    CH_ARMED = 2'd1,
    CH_PASS  = 2'd2,
    CH_FAIL  = 2'd3
  } ch_state_e;

  localparam int TMO_DISABLE = 0;
  localparam int X0_IDX      = 0;

endpackage

// File: rtl/reg_watch_channel.sv
// reg_watch_channel: one watch channel. Holds the FSM, the latched register
// index / expected value and the timeout down-counter.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   arm_i                      arm strobe (accepted handshake for this channel)
//   arm_hit_i                  value already present at arm time (PASS directly)
//   cfg_reg_i/value_i/timeout_i  arm parameters, latched on arm_i
//   wb_en_i/addr_i/data_i      snooped register-file write-back bus
//   idle_o/armed_o/pass_o/fail_o  state decode of the state register
module reg_watch_channel
  import reg_watch_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int TMO_W      = 20
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  arm_i,
  input  logic                  arm_hit_i,
  input  logic [REG_ADDR_W-1:0] cfg_reg_i,
  input  logic [DATA_W-1:0]     cfg_value_i,
  input  logic [TMO_W-1:0]      cfg_timeout_i,
  input  logic                  wb_en_i,
  input  logic [REG_ADDR_W-1:0] wb_addr_i,
  input  logic [DATA_W-1:0]     wb_data_i,
  output logic                  idle_o,
  output logic                  armed_o,
  output logic                  pass_o,
  output logic                  fail_o
);

  ch_state_e               state_q, state_d;
  logic [REG_ADDR_W-1:0]   reg_q, reg_d;
  logic [DATA_W-1:0]       value_q, value_d;
  logic [TMO_W-1:0]        cnt_q, cnt_d;
  logic                    match_s;

  // Writes to x0 are discarded by the register file, so they never count.
  assign match_s = wb_en_i
                && (wb_addr_i != REG_ADDR_W'(X0_IDX))
                && (wb_addr_i == reg_q)
                && (wb_data_i == value_q);

  // Next-state logic: arm has priority (only reachable when not ARMED), then
  // match beats expiry in the ARMED state.
  always_comb begin
    state_d = state_q;
    reg_d   = reg_q;
    value_d = value_q;
    cnt_d   = cnt_q;
    if (arm_i) begin
      reg_d   = cfg_reg_i;
      value_d = cfg_value_i;
      cnt_d   = cfg_timeout_i;
      if (arm_hit_i) begin
        state_d = CH_PASS;
      end else begin
        state_d = CH_ARMED;
      end
    end else begin
      case (state_q)
        CH_ARMED: begin
          if (match_s) begin
            state_d = CH_PASS;
          end else if (cnt_q == TMO_W'(1)) begin
            state_d = CH_FAIL;
          end else if (cnt_q != TMO_W'(TMO_DISABLE)) begin
            cnt_d = cnt_q - TMO_W'(1);
          end else begin
            cnt_d = cnt_q;
          end
        end
        CH_IDLE, CH_PASS, CH_FAIL: begin
          state_d = state_q;
        end
        default: begin
          state_d = CH_IDLE;
        end
      endcase
    end
  end

  // Channel state, latched watch parameters and timeout counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CH_IDLE;
      reg_q   <= '0;
      value_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      reg_q   <= reg_d;
      value_q <= value_d;
      cnt_q   <= cnt_d;
    end
  end

  assign idle_o  = (state_q == CH_IDLE);
  assign armed_o = (state_q == CH_ARMED);
  assign pass_o  = (state_q == CH_PASS);
  assign fail_o  = (state_q == CH_FAIL);

endmodule

// File: rtl/reg_watch_monitor.sv
// reg_watch_monitor: NUM_CH concurrent register watches on the CPU write-back
// port, each resolving to sticky PASS (value written) or FAIL (timeout).
// Optional feature macro: REG_WATCH_SHADOW_EN -- keeps a shadow copy of the
// register file so a channel armed on a register that already holds the
// expected value (including a same-cycle write) passes immediately.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   wb_en, wb_addr, wb_data    snooped write-back bus
//   cfg_valid/cfg_ready        arm handshake; ready low while cfg_ch is ARMED
//   cfg_ch, cfg_reg, cfg_value, cfg_timeout  arm parameters (timeout 0 = none)
//   ch_armed, ch_pass, ch_fail per-channel status
//   all_done                   nothing ARMED and at least one channel used
//   any_fail                   OR of ch_fail
module reg_watch_monitor
  import reg_watch_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int TMO_W      = 20,
  parameter int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wb_en,
  input  logic [REG_ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0]     wb_data,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [CH_W-1:0]       cfg_ch,
  input  logic [REG_ADDR_W-1:0] cfg_reg,
  input  logic [DATA_W-1:0]     cfg_value,
  input  logic [TMO_W-1:0]      cfg_timeout,
  output logic [NUM_CH-1:0]     ch_armed,
  output logic [NUM_CH-1:0]     ch_pass,
  output logic [NUM_CH-1:0]     ch_fail,
  output logic                  all_done,
  output logic                  any_fail
);

  logic [NUM_CH-1:0] idle_s;
  logic [NUM_CH-1:0] armed_s;
  logic [NUM_CH-1:0] pass_s;
  logic [NUM_CH-1:0] fail_s;
  logic [NUM_CH-1:0] arm_s;
  logic              arm_hit_s;

  // Ready only for an existing channel that is not currently waiting.
  always_comb begin
    cfg_ready = 1'b0;
    if (int'(cfg_ch) < NUM_CH) begin
      cfg_ready = ~armed_s[cfg_ch];
    end else begin
      cfg_ready = 1'b0;
    end
  end

`ifdef REG_WATCH_SHADOW_EN
  localparam int NUM_REGS = 2 ** REG_ADDR_W;

  logic [DATA_W-1:0] shadow_q [NUM_REGS];
  logic [DATA_W-1:0] shadow_d [NUM_REGS];
  logic [DATA_W-1:0] arm_cur_s;

  // Mirror every write-back; entry 0 stays zero like the real x0.
  always_comb begin
    shadow_d = shadow_q;
    if (wb_en && (wb_addr != REG_ADDR_W'(X0_IDX))) begin
      shadow_d[wb_addr] = wb_data;
    end else begin
      shadow_d[wb_addr] = shadow_q[wb_addr];
    end
    shadow_d[X0_IDX] = '0;
  end

  // Shadow register file storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        shadow_q[i] <= '0;
      end
    end else begin
      shadow_q <= shadow_d;
    end
  end

  // Current value of the watched register, forwarding a same-cycle write.
  always_comb begin
    if (wb_en && (wb_addr == cfg_reg) && (wb_addr != REG_ADDR_W'(X0_IDX))) begin
      arm_cur_s = wb_data;
    end else begin
      arm_cur_s = shadow_q[cfg_reg];
    end
  end

  assign arm_hit_s = (arm_cur_s == cfg_value);
`else
  assign arm_hit_s = 1'b0;
`endif

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign arm_s[i] = cfg_valid && cfg_ready && (cfg_ch == CH_W'(i));

    reg_watch_channel #(
      .DATA_W     (DATA_W),
      .REG_ADDR_W (REG_ADDR_W),
      .TMO_W      (TMO_W)
    ) u_ch (
      .clk           (clk),
      .rst_n         (rst_n),
      .arm_i         (arm_s[i]),
      .arm_hit_i     (arm_hit_s),
      .cfg_reg_i     (cfg_reg),
      .cfg_value_i   (cfg_value),
      .cfg_timeout_i (cfg_timeout),
      .wb_en_i       (wb_en),
      .wb_addr_i     (wb_addr),
      .wb_data_i     (wb_data),
      .idle_o        (idle_s[i]),
      .armed_o       (armed_s[i]),
      .pass_o        (pass_s[i]),
      .fail_o        (fail_s[i])
    );
  end

  assign ch_armed = armed_s;
  assign ch_pass  = pass_s;
  assign ch_fail  = fail_s;
  assign all_done = ~(|armed_s) & ~(&idle_s);
  assign any_fail = |fail_s;

endmodule

// File: tb/tb_reg_watch_monitor.sv
module tb_reg_watch_monitor;

  localparam int NUM_CH     = 4;
  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;
  localparam int TMO_W      = 20;
  localparam int CH_W       = 2;
  localparam int NUM_REGS   = 32;
  localparam int SW         = 3 * NUM_CH + 2;

  localparam int M_IDLE  = 0;
  localparam int M_ARMED = 1;
  localparam int M_PASS  = 2;
  localparam int M_FAIL  = 3;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  wb_en = 1'b0;
  logic [REG_ADDR_W-1:0] wb_addr = '0;
  logic [DATA_W-1:0]     wb_data = '0;
  logic                  cfg_valid = 1'b0;
  logic                  cfg_ready;
  logic [CH_W-1:0]       cfg_ch = '0;
  logic [REG_ADDR_W-1:0] cfg_reg = '0;
  logic [DATA_W-1:0]     cfg_value = '0;
  logic [TMO_W-1:0]      cfg_timeout = '0;
  logic [NUM_CH-1:0]     ch_armed, ch_pass, ch_fail;
  logic                  all_done, any_fail;

  int checks = 0;
  int errors = 0;

  // Reference model: per channel status, watched reg/value and the absolute
  // cycle at which it expires (0 = never); plus a plain copy of the reg file.
  int                    m_st  [NUM_CH];
  logic [REG_ADDR_W-1:0] m_reg [NUM_CH];
  logic [DATA_W-1:0]     m_val [NUM_CH];
  int                    m_dl  [NUM_CH];
  logic [DATA_W-1:0]     m_shadow [NUM_REGS];
  int                    cyc = 0;

  reg_watch_monitor #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W), .TMO_W(TMO_W), .CH_W(CH_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
    .cfg_reg(cfg_reg), .cfg_value(cfg_value), .cfg_timeout(cfg_timeout),
    .ch_armed(ch_armed), .ch_pass(ch_pass), .ch_fail(ch_fail),
    .all_done(all_done), .any_fail(any_fail)
  );

  always #5 clk = ~clk;

  function automatic logic [SW-1:0] model_status();
    logic [NUM_CH-1:0] a, p, f;
    logic busy;
    busy = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      a[i] = (m_st[i] == M_ARMED);
      p[i] = (m_st[i] == M_PASS);
      f[i] = (m_st[i] == M_FAIL);
      if (m_st[i] != M_IDLE) busy = 1'b1;
    end
    return {a, p, f, (~(|a)) & busy, |f};
  endfunction

  function automatic logic model_ready();
    return (m_st[cfg_ch] != M_ARMED);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_st[i] = M_IDLE; m_reg[i] = '0; m_val[i] = '0; m_dl[i] = 0;
    end
    for (int r = 0; r < NUM_REGS; r++) m_shadow[r] = '0;
  endtask

  // Apply the rules to the inputs presented at the coming clock edge.
  task automatic model_edge();
    logic rdy;
    logic [DATA_W-1:0] cur;
    logic wr_ok;
    cyc++;
    rdy   = model_ready();
    wr_ok = wb_en && (wb_addr != 0);
    for (int i = 0; i < NUM_CH; i++) begin
      if (m_st[i] == M_ARMED) begin
        if (wr_ok && wb_addr == m_reg[i] && wb_data == m_val[i]) m_st[i] = M_PASS;
        else if (m_dl[i] != 0 && cyc == m_dl[i]) m_st[i] = M_FAIL;
      end
    end
    if (cfg_valid && rdy) begin
      m_reg[cfg_ch] = cfg_reg;
      m_val[cfg_ch] = cfg_value;
      m_dl[cfg_ch]  = (cfg_timeout == 0) ? 0 : cyc + int'(cfg_timeout);
      cur = (wr_ok && wb_addr == cfg_reg) ? wb_data : m_shadow[cfg_reg];
`ifdef REG_WATCH_SHADOW_EN
      m_st[cfg_ch] = (cur == cfg_value) ? M_PASS : M_ARMED;
`else
      m_st[cfg_ch] = M_ARMED;
      if (cur == '1) cur = '0;
`endif
    end
    if (wr_ok) m_shadow[wb_addr] = wb_data;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    wb_en = 1'b0;
    cfg_valid = 1'b0;
  endtask

  task automatic arm(input int ch, input int r, input logic [DATA_W-1:0] v, input int t);
    cfg_valid   = 1'b1;
    cfg_ch      = CH_W'(ch);
    cfg_reg     = REG_ADDR_W'(r);
    cfg_value   = v;
    cfg_timeout = TMO_W'(t);
  endtask

  task automatic wb(input int r, input logic [DATA_W-1:0] d);
    wb_en   = 1'b1;
    wb_addr = REG_ADDR_W'(r);
    wb_data = d;
  endtask

  task automatic do_reset();
    wb_en = 1'b0;
    cfg_valid = 1'b0;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    logic [SW-1:0] obs;
    do_reset();
    obs = {ch_armed, ch_pass, ch_fail, all_done, any_fail};
    checks++;
    if (obs !== '0) begin
      errors++; $display("FAIL reset_status: got %h expected 0", obs);
    end
    checks++;
    if (cfg_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready: got %b expected 1", cfg_ready);
    end
  endtask

  task automatic test_pass();
    logic [SW-1:0] obs, exp;
    do_reset();
    arm(0, 5, 32'h10, 100);
    step();
    repeat (19) step();
    obs = {ch_armed, ch_pass, ch_fail, all_done, any_fail}; exp = model_status();
    checks++;
    if (obs !== exp || ch_armed[0] !== 1'b1) begin
      errors++; $display("FAIL pass_wait: got %h expected %h", obs, exp);
    end
    wb(5, 32'h10);
    step();
    obs = {ch_armed, ch_pass, ch_fail, all_done, any_fail}; exp = model_status();
    checks++;
    if (obs !== exp) begin
      errors++; $display("FAIL pass_model: got %h expected %h", obs, exp);
    end
    checks++;
    if ({ch_pass[0], all_done, any_fail} !== 3'b110) begin
      errors++; $display("FAIL pass_flags: got %b expected 110", {ch_pass[0], all_done, any_fail});
    end
  endtask

  task automatic test_timeout();
    logic [SW-1:0] obs, exp;
    do_reset();
    arm(1, 7, 32'hDEAD, 8);
    step();
    for (int k = 1; k <= 8; k++) begin
      wb(($urandom_range(0, 1) == 0) ? 7 : int'($urandom_range(1, 31)),
         32'hDEAD ^ 32'($urandom_range(1, 255)));
      step();
      obs = {ch_armed, ch_pass, ch_fail, all_done, any_fail}; exp = model_status();
      checks++;
      if (obs !== exp) begin
        errors++; $display("FAIL timeout_k%0d: got %h expected %h", k, obs, exp);
      end
      if (k == 7) begin
        checks++;
        if (ch_fail[1] !== 1'b0) begin
          errors++; $display("FAIL timeout_early: ch_fail[1]=%b expected 0", ch_fail[1]);
        end
      end
    end
    checks++;
    if ({ch_fail[1], any_fail} !== 2'b11) begin
      errors++; $display("FAIL timeout_final: got %b expected 11", {ch_fail[1], any_fail});
    end
  endtask

  task automatic test_multi();
    logic [SW-1:0] obs, exp;
    do_reset();
    arm(0, 3, 32'd42, 0); step();
    arm(2, 3, 32'd42, 0); step();
    wb(3, 32'd41); step();
    obs = {ch_armed, ch_pass, ch_fail, all_done, any_fail}; exp = model_status();
    checks++;
    if (obs !== exp || ch_armed !== 4'b0101) begin
      errors++; $display("FAIL multi_nomatch: got %h expected %h", obs, exp);
    end
    wb(3, 32'd42); step();
    obs = {ch_armed, ch_pass, ch_fail, all_done, any_fail}; exp = model_status();
    checks++;
    if (obs !== exp || ch_pass !== 4'b0101) begin
      errors++; $display("FAIL multi_both: got %h expected %h", obs, exp);
    end
  endtask

  task automatic test_expiry_match();
    logic [SW-1:0] obs, exp;
    logic [DATA_W-1:0] v;
    do_reset();
    v = $urandom;
    arm(3, 12, v, 4); step();
    repeat (3) step();
    checks++;
    if (ch_armed[3] !== 1'b1) begin
      errors++; $display("FAIL expiry_wait: ch_armed[3]=%b expected 1", ch_armed[3]);
    end
    wb(12, v); step();
    obs = {ch_armed, ch_pass, ch_fail, all_done, any_fail}; exp = model_status();
    checks++;
    if (obs !== exp || {ch_pass[3], ch_fail[3]} !== 2'b10) begin
      errors++; $display("FAIL expiry_match: got %h expected %h", obs, exp);
    end
  endtask

  task automatic test_reset_mid();
    logic [SW-1:0] obs, exp;
    do_reset();
    arm(0, 4, 32'd1, 50); step();
    repeat (3) step();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    obs = {ch_armed, ch_pass, ch_fail, all_done, any_fail};
    checks++;
    if (obs !== '0) begin
      errors++; $display("FAIL midreset_async: got %h expected 0", obs);
    end
    @(posedge clk);
    #2 rst_n = 1'b1;
    step();
    obs = {ch_armed, ch_pass, ch_fail, all_done, any_fail};
    checks++;
    if (obs !== '0) begin
      errors++; $display("FAIL midreset_after: got %h expected 0", obs);
    end
    // Busy channel rejects a new request.
    arm(0, 4, 32'd1, 0); step();
    arm(0, 6, 32'd2, 0);
    #1;
    checks++;
    if (cfg_ready !== 1'b0 || cfg_ready !== model_ready()) begin
      errors++; $display("FAIL busy_ready: got %b expected 0", cfg_ready);
    end
    step();
    wb(6, 32'd2); step();
    obs = {ch_armed, ch_pass, ch_fail, all_done, any_fail}; exp = model_status();
    checks++;
    if (obs !== exp || ch_armed[0] !== 1'b1) begin
      errors++; $display("FAIL busy_ignored: got %h expected %h", obs, exp);
    end
    wb(4, 32'd1); step();
    checks++;
    if (ch_pass[0] !== 1'b1) begin
      errors++; $display("FAIL busy_orig_pass: ch_pass[0]=%b expected 1", ch_pass[0]);
    end
  endtask

  task automatic test_shadow();
    logic [SW-1:0] obs, exp;
    logic exp_pass;
`ifdef REG_WATCH_SHADOW_EN
    exp_pass = 1'b1;
`else
    exp_pass = 1'b0;
`endif
    do_reset();
    wb(9, 32'd7); step();
    arm(2, 9, 32'd7, 0); step();
    obs = {ch_armed, ch_pass, ch_fail, all_done, any_fail}; exp = model_status();
    checks++;
    if (obs !== exp || {ch_pass[2], ch_armed[2]} !== {exp_pass, ~exp_pass}) begin
      errors++; $display("FAIL shadow_hold: got %h expected %h", obs, exp);
    end
    // Arm with a same-cycle matching write.
    arm(1, 10, 32'd5, 0); wb(10, 32'd5); step();
    checks++;
    if ({ch_pass[1], ch_armed[1]} !== {exp_pass, ~exp_pass}) begin
      errors++; $display("FAIL shadow_fwd: got %b expected %b", {ch_pass[1], ch_armed[1]}, {exp_pass, ~exp_pass});
    end
    // x0 is never matched by a write; only the shadow (reads 0) can pass it.
    arm(3, 0, 32'd0, 3); step();
    wb(0, 32'd0); step();
    repeat (2) step();
    obs = {ch_armed, ch_pass, ch_fail, all_done, any_fail}; exp = model_status();
    checks++;
    if (obs !== exp || {ch_pass[3], ch_fail[3]} !== {exp_pass, ~exp_pass}) begin
      errors++; $display("FAIL x0_watch: got %h expected %h", obs, exp);
    end
  endtask

  task automatic test_random();
    logic [SW-1:0] obs, exp;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 9) < 3) begin
        arm(int'($urandom_range(0, NUM_CH - 1)), int'($urandom_range(0, 7)),
            32'($urandom_range(0, 3)), int'($urandom_range(0, 12)));
      end
      if ($urandom_range(0, 1) == 1) begin
        wb(int'($urandom_range(0, 7)), 32'($urandom_range(0, 3)));
      end
      #1;
      checks++;
      if (cfg_ready !== model_ready()) begin
        errors++; $display("FAIL rand_ready n=%0d: got %b expected %b", n, cfg_ready, model_ready());
      end
      step();
      obs = {ch_armed, ch_pass, ch_fail, all_done, any_fail}; exp = model_status();
      checks++;
      if (obs !== exp) begin
        errors++; $display("FAIL rand_status n=%0d: got %h expected %h", n, obs, exp);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_pass();
    test_timeout();
    test_multi();
    test_expiry_match();
    test_reset_mid();
    test_shadow();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_watch_monitor.md
Name: reg_watch_monitor

Overview:
Parametrised multi-channel register-watch engine. It snoops the CPU register-file write-back port and resolves each armed channel to PASS or FAIL.
- PASS: the watched register receives the expected value.
- FAIL: the channel's cycle timeout expires first.
- Generalises the single-register, unbounded wait-for-value check into NUM_CH concurrent watches with timeouts and sticky status.
- Sits beside Riscv151 in simulation and FPGA-debug builds, driven by a bench or a small debug controller.

Parameters:
NUM_CH, 4, number of independent watch channels (1..16)
DATA_W, 32, register data width
REG_ADDR_W, 5, register index width (NUM_REGS = 2**REG_ADDR_W)
TMO_W, 20, timeout counter width

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
wb_en  in  1  register-file write enable, snooped
wb_addr  in  REG_ADDR_W  write-back register index
wb_data  in  DATA_W  write-back data
cfg_valid  in  1  arm request
cfg_ready  out  1  arm request accepted this cycle
cfg_ch  in  $clog2(NUM_CH)  channel to arm
cfg_reg  in  REG_ADDR_W  register to watch
cfg_value  in  DATA_W  expected value
cfg_timeout  in  TMO_W  cycles allowed; 0 = no timeout
ch_armed  out  NUM_CH  channel in ARMED
ch_pass  out  NUM_CH  channel resolved PASS (sticky)
ch_fail  out  NUM_CH  channel resolved FAIL (sticky)
all_done  out  1  no channel ARMED and at least one channel not IDLE
any_fail  out  1  OR of ch_fail

Behaviour:
- Reset (async assert, sync release): all channels IDLE, counters 0, all outputs 0.
- Per-channel FSM states: IDLE, ARMED, PASS, FAIL. Status outputs are registered straight from the state.
- cfg_ready = 0 when channel cfg_ch is ARMED, else 1. Combinational from cfg_ch and state.
- Handshake: cfg_valid && cfg_ready arms the channel.
  - Latches cfg_reg, cfg_value, cfg_timeout.
  - Channel is ARMED on the next cycle.
  - Re-arming a PASS/FAIL channel clears its status.
- Same-cycle write: a write-back in the arm cycle is not matched by that channel unless SHADOW is enabled.
- Match: in ARMED, wb_en && wb_addr == reg && wb_data == value moves the channel to PASS next cycle.
- Register x0: writes with wb_addr == 0 never match (x0 is hardwired 0).
- Timeout:
  - Counter loads cfg_timeout at arm and decrements each ARMED cycle.
  - When counter == 1 and no match that cycle, the channel goes to FAIL next cycle.
  - cfg_timeout == 0 disables the timeout.
  - Match and expiry in the same cycle resolve to PASS.
- Concurrency: one write may resolve several channels in the same cycle.
- Multiple wb_en: only one write per cycle is assumed by the port.
- Cycle-level: PASS/FAIL visible exactly 1 cycle after the deciding edge.
- Reset mid-operation: every channel returns to IDLE immediately; no residual status.

Optional Feature:
REG_WATCH_SHADOW_EN
- With it: a NUM_REGS x DATA_W shadow register file tracks all write-backs; x0 reads 0.
  - At arm, if shadow[cfg_reg] == cfg_value, the channel goes directly to PASS next cycle.
  - A same-cycle write-back to cfg_reg is forwarded into that compare.
  - Matches "already holds value" semantics.
- Without it: no shadow storage; a channel only passes on a write observed while ARMED.

Decomposition:
- Package reg_watch_pkg holds:
  - channel state enum (IDLE/ARMED/PASS/FAIL)
  - TMO disable constant 0
  - x0 index constant
- One natural sub-module, reg_watch_channel, instantiated NUM_CH times:
  - contains the FSM, latched reg/value, and timeout counter
  - takes the snooped wb bus and its arm strobe
- Top level holds cfg decode, the optional shadow array, and the all_done/any_fail reduction.

Test Plan:
1. Arm ch0 for reg 5 = 0x10, timeout 100; write x5 = 0x10 at cycle 20 -> ch_pass[0] = 1 at cycle 21, all_done = 1, any_fail = 0.
2. Arm ch1 for reg 7 = 0xDEAD, timeout 8; no matching write -> ch_fail[1] = 1 exactly 8 cycles after ARMED, any_fail = 1.
3. Arm ch0 and ch2 for reg 3 = 42; single write x3 = 42 -> both pass in the same cycle. Write x3 = 41 first -> no status change.
4. Arm a channel with timeout 4; matching write lands in the expiry cycle -> PASS, not FAIL.
5. Arm ch0, then assert rst_n = 0 for 1 cycle mid-wait -> all outputs 0, ch0 IDLE. Cfg on an ARMED channel -> cfg_ready = 0 and the request is ignored.
6. With REG_WATCH_SHADOW_EN, write x9 = 7, then arm reg 9 = 7 -> PASS next cycle without a further write. Without the macro the same sequence stays ARMED.
